// File: rtl/vec_hazard_scoreboard_pkg.sv
// Shared constants for the vector hazard scoreboard: register index width,
// forwarding select encoding and a constant-evaluable ceil(log2) helper.
package vec_hazard_scoreboard_pkg;

    localparam int REG_BITS_DEF = 5;
    localparam int FW_SEL_RF    = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_hazard_scoreboard_fw_sel.sv
// Priority encoder for one source operand: the nearest writing stage whose
// destination equals rs wins; x0 never matches.
module fw_priority_sel
    import vec_hazard_scoreboard_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF,
    parameter int NUM_STG  = 3,
    parameter int SEL_BITS = clog2(NUM_STG + 1)
) (
    input  logic [REG_BITS-1:0]         i_rs,
    input  logic [NUM_STG*REG_BITS-1:0] i_stg_rd,
    input  logic [NUM_STG-1:0]          i_stg_wr_en,
    input  logic [NUM_STG-1:0]          i_stg_rdy,
    output logic                        o_match,
    output logic [SEL_BITS-1:0]         o_sel,
    output logic                        o_rdy_n
);

    // Walk from the oldest stage down so the nearest match is written last.
    always_comb begin
        o_match = 1'b0;
        o_sel   = SEL_BITS'(FW_SEL_RF);
        o_rdy_n = 1'b0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (i_stg_wr_en[k] && (i_stg_rd[k*REG_BITS +: REG_BITS] == i_rs) &&
                (i_rs != '0)) begin
                o_match = 1'b1;
                o_sel   = SEL_BITS'(k + 1);
                o_rdy_n = !i_stg_rdy[k];
            end
        end
    end

endmodule

// File: rtl/vec_hazard_scoreboard.sv
// ID-stage hazard unit: per-source forwarding selects, RAW/WAW stall, a
// pending-write scoreboard and a saturating stall-cycle counter.
module vec_hazard_scoreboard
    import vec_hazard_scoreboard_pkg::*;
#(
    parameter int REG_BITS = REG_BITS_DEF,
    parameter int NUM_SRC  = 3,
    parameter int NUM_STG  = 3,
    parameter int SEL_BITS = clog2(NUM_STG + 1),
    parameter int CNT_BITS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_BITS-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic [REG_BITS-1:0]          id_rd,
    input  logic                         id_wr_en,
    input  logic                         flush,
    input  logic [NUM_STG*REG_BITS-1:0]  stg_rd,
    input  logic [NUM_STG-1:0]           stg_wr_en,
    input  logic [NUM_STG-1:0]           stg_rdy,
    input  logic [REG_BITS-1:0]          wb_rd,
    input  logic                         wb_wr_en,
    output logic [NUM_SRC*SEL_BITS-1:0]  fw_sel,
    output logic                         stall,
    output logic                         issue,
    output logic [(2**REG_BITS)-1:0]     pending,
    output logic [CNT_BITS-1:0]          stall_cnt
);

    localparam int NUM_REGS = 2**REG_BITS;

    logic [NUM_REGS-1:0]         r_pending;
    logic [CNT_BITS-1:0]         r_stall_cnt;
    logic [NUM_REGS-1:0]         w_pending_nxt;
    logic [REG_BITS-1:0]         w_rs [NUM_SRC];
    logic [NUM_SRC-1:0]          w_match;
    logic [NUM_SRC-1:0]          w_rdy_n;
    logic [NUM_SRC-1:0]          w_hzd;
    logic [NUM_SRC*SEL_BITS-1:0] w_sel;
    logic                        w_waw;
    logic                        w_stall;
    logic                        w_issue;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_rs[gi] = id_rs[gi*REG_BITS +: REG_BITS];
            fw_priority_sel #(
                .REG_BITS (REG_BITS),
                .NUM_STG  (NUM_STG),
                .SEL_BITS (SEL_BITS)
            ) u_fw_sel (
                .i_rs        (w_rs[gi]),
                .i_stg_rd    (stg_rd),
                .i_stg_wr_en (stg_wr_en),
                .i_stg_rdy   (stg_rdy),
                .o_match     (w_match[gi]),
                .o_sel       (w_sel[gi*SEL_BITS +: SEL_BITS]),
                .o_rdy_n     (w_rdy_n[gi])
            );
        end
    endgenerate

    // Without a stage match, a pending producer only stops hazarding once it
    // is on the writeback port this very cycle.
    always_comb begin
        w_hzd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_match[i]) begin
                w_hzd[i] = w_rdy_n[i];
            end else begin
                w_hzd[i] = r_pending[w_rs[i]] && !(wb_wr_en && (wb_rd == w_rs[i]));
            end
            w_hzd[i] = w_hzd[i] && id_rs_used[i] && (w_rs[i] != '0);
        end
    end

    assign w_waw   = id_wr_en && (id_rd != '0) && r_pending[id_rd] &&
                     !(wb_wr_en && (wb_rd == id_rd));
    assign w_stall = !rst && id_valid && !flush && ((|w_hzd) || w_waw);
    assign w_issue = !rst && id_valid && !flush && !w_stall;

    // Set is applied after clear so a same-cycle retire and reissue stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_wr_en && (wb_rd != '0)) begin
            w_pending_nxt[wb_rd] = 1'b0;
        end
        if (w_issue && id_wr_en && (id_rd != '0)) begin
            w_pending_nxt[id_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign fw_sel    = rst ? '0 : w_sel;
    assign stall     = w_stall;
    assign issue     = w_issue;
    assign pending   = r_pending;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_vec_hazard_scoreboard.sv
// Self-checking bench for vec_hazard_scoreboard: table vectors for the
// combinational forwarding paths plus hand-built multi-cycle sequences.
module tb_vec_hazard_scoreboard;

    localparam int RB = 5;
    localparam int NS = 3;
    localparam int NG = 3;
    localparam int SB = 2;
    localparam int CB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [NS*RB-1:0] id_rs;
    logic [NS-1:0]   id_rs_used;
    logic [RB-1:0]   id_rd;
    logic            id_wr_en;
    logic            flush;
    logic [NG*RB-1:0] stg_rd;
    logic [NG-1:0]   stg_wr_en;
    logic [NG-1:0]   stg_rdy;
    logic [RB-1:0]   wb_rd;
    logic            wb_wr_en;
    logic [NS*SB-1:0] fw_sel;
    logic            stall;
    logic            issue;
    logic [31:0]     pending;
    logic [CB-1:0]   stall_cnt;

    always #5 clk = ~clk;

    vec_hazard_scoreboard #(
        .REG_BITS (RB), .NUM_SRC (NS), .NUM_STG (NG), .SEL_BITS (SB), .CNT_BITS (CB)
    ) dut (
        .clk (clk), .rst (rst), .id_valid (id_valid), .id_rs (id_rs),
        .id_rs_used (id_rs_used), .id_rd (id_rd), .id_wr_en (id_wr_en),
        .flush (flush), .stg_rd (stg_rd), .stg_wr_en (stg_wr_en),
        .stg_rdy (stg_rdy), .wb_rd (wb_rd), .wb_wr_en (wb_wr_en),
        .fw_sel (fw_sel), .stall (stall), .issue (issue),
        .pending (pending), .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic        valid;
        logic        flsh;
        logic [14:0] rs;
        logic [2:0]  used;
        logic [14:0] srd;
        logic [2:0]  swr;
        logic [2:0]  srdy;
        logic [5:0]  e_fw;
        logic        e_stall;
        logic        e_issue;
    } vec_t;

    vec_t        vecs [11];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  exp_q[$];
    string       name_q[$];
    logic [31:0] exp_pend = '0;
    logic [CB-1:0] exp_cnt = '0;
    logic        last_stall = 1'b0;
    logic        last_issue = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_exp(input string nm, input logic [5:0] fw, input logic st,
                            input logic is);
        exp_q.push_back({fw, st, is});
        name_q.push_back(nm);
        last_stall = st;
        last_issue = is;
    endtask

    // Compares combinational outputs against the queue head, and the registered
    // state against the bench model, on the falling edge.
    task automatic cmp_out();
        logic [7:0] e;
        string      nm;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL queue_underflow: no expected entry at time %0t", $time);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, "_out"}, {56'd0, fw_sel, stall, issue}, {56'd0, e});
            chk({nm, "_pending"}, {32'd0, pending}, {32'd0, exp_pend});
            chk({nm, "_stall_cnt"}, {60'd0, stall_cnt}, {60'd0, exp_cnt});
        end
    endtask

    task automatic tick();
        if (rst) begin
            exp_pend = '0;
            exp_cnt  = '0;
        end else begin
            if (last_stall && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
            if (wb_wr_en && (wb_rd != '0)) exp_pend[wb_rd] = 1'b0;
            if (last_issue && id_wr_en && (id_rd != '0)) exp_pend[id_rd] = 1'b1;
        end
        last_stall = 1'b0;
        last_issue = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_wr_en = 1'b0;
        flush = 1'b0; stg_rd = '0; stg_wr_en = '0; stg_rdy = '0;
        wb_rd = '0; wb_wr_en = 1'b0;
    endtask

    task automatic set_stg(input int k, input logic [RB-1:0] rd, input logic rdy);
        stg_rd[k*RB +: RB] = rd;
        stg_wr_en[k]       = 1'b1;
        stg_rdy[k]         = rdy;
    endtask

    task automatic id_write(input logic [RB-1:0] rd);
        clr();
        id_valid = 1'b1; id_wr_en = 1'b1; id_rd = rd;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, {5'd3, 5'd2, 5'd1}, 3'b111, 15'd0, 3'b000, 3'b000, 6'b000000, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, {5'd0, 5'd0, 5'd1}, 3'b001, {5'd0, 5'd0, 5'd1}, 3'b001, 3'b001, 6'b000001, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, {5'd0, 5'd1, 5'd1}, 3'b011, {5'd1, 5'd1, 5'd1}, 3'b111, 3'b111, 6'b000101, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, {5'd0, 5'd0, 5'd1}, 3'b001, {5'd1, 5'd1, 5'd1}, 3'b111, 3'b110, 6'b000001, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, {5'd0, 5'd2, 5'd0}, 3'b010, {5'd0, 5'd2, 5'd2}, 3'b010, 3'b010, 6'b001000, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, {5'd3, 5'd0, 5'd0}, 3'b100, {5'd3, 5'd0, 5'd0}, 3'b100, 3'b100, 6'b110000, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 15'd0, 3'b111, 15'd0, 3'b001, 3'b000, 6'b000000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, {5'd0, 5'd0, 5'd4}, 3'b000, {5'd0, 5'd0, 5'd4}, 3'b001, 3'b000, 6'b000001, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, {5'd0, 5'd0, 5'd1}, 3'b001, {5'd1, 5'd1, 5'd1}, 3'b111, 3'b110, 6'b000001, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, {5'd0, 5'd0, 5'd1}, 3'b001, {5'd1, 5'd1, 5'd1}, 3'b111, 3'b110, 6'b000001, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, {5'd3, 5'd2, 5'd1}, 3'b111, {5'd3, 5'd2, 5'd1}, 3'b111, 3'b101, 6'b111001, 1'b1, 1'b0};

        // Reset with a hazard and a forwarding match present: outputs forced low.
        clr();
        rst = 1'b1;
        tick();
        id_valid = 1'b1; id_rs = {5'd0, 5'd0, 5'd6}; id_rs_used = 3'b001;
        set_stg(0, 5'd6, 1'b0);
        push_exp("reset_forced", 6'b0, 1'b0, 1'b0);
        cmp_out();
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            clr();
            id_valid   = vecs[i].valid;
            flush      = vecs[i].flsh;
            id_rs      = vecs[i].rs;
            id_rs_used = vecs[i].used;
            stg_rd     = vecs[i].srd;
            stg_wr_en  = vecs[i].swr;
            stg_rdy    = vecs[i].srdy;
            push_exp($sformatf("vec%0d", i), vecs[i].e_fw, vecs[i].e_stall, vecs[i].e_issue);
            cmp_out();
            tick();
        end

        // Back-to-back ALU dependency on r5, then retire.
        id_write(5'd5);
        push_exp("b2b_issue", 6'b0, 1'b0, 1'b1);
        cmp_out(); tick();
        clr();
        id_valid = 1'b1; id_rs = {5'd0, 5'd0, 5'd5}; id_rs_used = 3'b001;
        set_stg(0, 5'd5, 1'b1);
        push_exp("b2b_fwd", 6'b000001, 1'b0, 1'b1);
        cmp_out();
        chk("b2b_pending5", {63'd0, pending[5]}, 64'd1);
        tick();
        clr(); wb_wr_en = 1'b1; wb_rd = 5'd5;
        push_exp("b2b_retire", 6'b0, 1'b0, 1'b0);
        cmp_out(); tick();
        clr();
        push_exp("b2b_idle", 6'b0, 1'b0, 1'b0);
        cmp_out();
        chk("b2b_pending5_clr", {63'd0, pending[5]}, 64'd0);
        tick();

        // Load-use on r7 through src1.
        clr();
        id_valid = 1'b1; id_rs = {5'd0, 5'd7, 5'd0}; id_rs_used = 3'b010;
        set_stg(0, 5'd7, 1'b0);
        push_exp("ldu_stall", 6'b000100, 1'b1, 1'b0);
        cmp_out(); tick();
        clr();
        id_valid = 1'b1; id_rs = {5'd0, 5'd7, 5'd0}; id_rs_used = 3'b010;
        set_stg(1, 5'd7, 1'b1);
        push_exp("ldu_fwd", 6'b001000, 1'b0, 1'b1);
        cmp_out(); tick();

        // Producer of r9 outside the tracked stages for three cycles.
        id_write(5'd9);
        push_exp("mc_issue", 6'b0, 1'b0, 1'b1);
        cmp_out(); tick();
        for (int n = 0; n < 3; n++) begin
            clr();
            id_valid = 1'b1; id_rs = {5'd0, 5'd0, 5'd9}; id_rs_used = 3'b001;
            push_exp($sformatf("mc_stall%0d", n), 6'b0, 1'b1, 1'b0);
            cmp_out(); tick();
        end
        clr();
        id_valid = 1'b1; id_rs = {5'd0, 5'd0, 5'd9}; id_rs_used = 3'b001;
        wb_wr_en = 1'b1; wb_rd = 5'd9;
        set_stg(NG - 1, 5'd9, 1'b1);
        push_exp("mc_wb_fwd", 6'b000011, 1'b0, 1'b1);
        cmp_out(); tick();

        // WAW on r4, then retire and reissue in the same cycle.
        id_write(5'd4);
        push_exp("waw_first", 6'b0, 1'b0, 1'b1);
        cmp_out(); tick();
        id_write(5'd4);
        push_exp("waw_stall", 6'b0, 1'b1, 1'b0);
        cmp_out(); tick();
        id_write(5'd4);
        wb_wr_en = 1'b1; wb_rd = 5'd4;
        push_exp("waw_retire_reissue", 6'b0, 1'b0, 1'b1);
        cmp_out(); tick();
        clr();
        push_exp("waw_after", 6'b0, 1'b0, 1'b0);
        cmp_out();
        chk("waw_pending4", {63'd0, pending[4]}, 64'd1);
        tick();

        // Flush with a RAW hazard on r4 and a write to r8: no stall, no set.
        id_write(5'd8);
        flush = 1'b1; id_rs = {5'd0, 5'd0, 5'd4}; id_rs_used = 3'b001;
        push_exp("flush_hzd", 6'b0, 1'b0, 1'b0);
        cmp_out(); tick();
        clr();
        push_exp("flush_after", 6'b0, 1'b0, 1'b0);
        cmp_out();
        chk("flush_pending8", {63'd0, pending[8]}, 64'd0);
        tick();

        // Long stall until the counter saturates.
        for (int n = 0; n < 20; n++) begin
            clr();
            id_valid = 1'b1; id_rs = {5'd0, 5'd0, 5'd4}; id_rs_used = 3'b001;
            push_exp($sformatf("sat%0d", n), 6'b0, 1'b1, 1'b0);
            cmp_out(); tick();
        end
        clr();
        push_exp("sat_hold", 6'b0, 1'b0, 1'b0);
        cmp_out();
        chk("stall_cnt_saturated", {60'd0, stall_cnt}, 64'hF);
        tick();

        // Add more pending bits, then reset mid-operation.
        id_write(5'd10);
        push_exp("pre_rst_a", 6'b0, 1'b0, 1'b1);
        cmp_out(); tick();
        id_write(5'd11);
        push_exp("pre_rst_b", 6'b0, 1'b0, 1'b1);
        cmp_out(); tick();
        clr();
        rst = 1'b1;
        id_valid = 1'b1; id_rs = {5'd11, 5'd10, 5'd4}; id_rs_used = 3'b111;
        set_stg(1, 5'd10, 1'b0);
        push_exp("rst_assert", 6'b0, 1'b0, 1'b0);
        cmp_out(); tick();
        push_exp("rst_held", 6'b0, 1'b0, 1'b0);
        cmp_out();
        chk("rst_pending_zero", {32'd0, pending}, 64'd0);
        tick();
        rst = 1'b0;
        clr();
        id_valid = 1'b1; id_rs = {5'd0, 5'd0, 5'd4}; id_rs_used = 3'b001;
        push_exp("post_rst_no_hzd", 6'b0, 1'b0, 1'b1);
        cmp_out(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
